// File: rtl/atr_pkg.sv
// rtl/atr_pkg.sv - shared encodings and register map for the ATR controller
package atr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_TX_PEND = 3'd2,
    ST_TX      = 3'd3,
    ST_RX_PEND = 3'd4
  } atr_fsm_e;

  localparam logic [1:0] CLS_IDLE = 2'd0;
  localparam logic [1:0] CLS_RX   = 2'd1;
  localparam logic [1:0] CLS_TX   = 2'd2;
  localparam logic [1:0] CLS_FDX  = 2'd3;

  // Offsets relative to BASE_ADDR
  localparam logic [7:0] OFF_CTRL    = 8'd0;
  localparam logic [7:0] OFF_TX_DLY  = 8'd1;
  localparam logic [7:0] OFF_RX_DLY  = 8'd2;
  localparam logic [7:0] OFF_BANK0   = 8'd8;
  localparam int         BANK_STRIDE = 8;

  // Offsets inside one bank window
  localparam logic [2:0] OFF_IO       = 3'd0;
  localparam logic [2:0] OFF_MASK     = 3'd1;
  localparam logic [2:0] OFF_VAL_IDLE = 3'd2;
  localparam logic [2:0] OFF_VAL_RX   = 3'd3;
  localparam logic [2:0] OFF_VAL_TX   = 3'd4;
  localparam logic [2:0] OFF_VAL_FDX  = 3'd5;

  function automatic logic [1:0] atr_class(input logic transmitting,
                                           input logic fdx_mode,
                                           input logic rx_en);
    return transmitting ? ((fdx_mode && rx_en) ? CLS_FDX : CLS_TX)
                        : (rx_en ? CLS_RX : CLS_IDLE);
  endfunction

endpackage

// File: rtl/atr_bank.sv
// rtl/atr_bank.sv - one GPIO bank: registers, masked IO write, ATR output mux
module atr_bank
  import atr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [31:0]      wr_data,
  input  logic             atr_en,
  input  logic [1:0]       cls,
  output logic [WIDTH-1:0] io_out
);

  logic [WIDTH-1:0] io_q, mask_q, val_idle_q, val_rx_q, val_tx_q, val_fdx_q;
  logic [WIDTH-1:0] wr_val, wr_mask, val_sel;

  assign wr_val  = wr_data[0 +: WIDTH];
  assign wr_mask = wr_data[16 +: WIDTH];

  // Register file; an IO write only changes bits whose upper-half mask bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_q       <= '0;
      mask_q     <= '0;
      val_idle_q <= '0;
      val_rx_q   <= '0;
      val_tx_q   <= '0;
      val_fdx_q  <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        OFF_IO:       io_q       <= (io_q & ~wr_mask) | (wr_val & wr_mask);
        OFF_MASK:     mask_q     <= wr_val;
        OFF_VAL_IDLE: val_idle_q <= wr_val;
        OFF_VAL_RX:   val_rx_q   <= wr_val;
        OFF_VAL_TX:   val_tx_q   <= wr_val;
        OFF_VAL_FDX:  val_fdx_q  <= wr_val;
        default: ;
      endcase
    end
  end

  // Select the ATR value belonging to the current class
  always_comb begin
    val_sel = val_idle_q;
    case (cls)
      CLS_RX:  val_sel = val_rx_q;
      CLS_TX:  val_sel = val_tx_q;
      CLS_FDX: val_sel = val_fdx_q;
      default: val_sel = val_idle_q;
    endcase
  end

  // Registered pin drive; with ATR disabled the plain IO register owns every bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_out <= '0;
    end else begin
      io_out <= atr_en ? ((mask_q & val_sel) | (~mask_q & io_q)) : io_q;
    end
  end

endmodule

// File: rtl/atr_controller_n.sv
// rtl/atr_controller_n.sv - automatic TX/RX GPIO controller with delayed switching
module atr_controller_n
  import atr_pkg::*;
#(
  parameter int         NUM_BANKS = 4,
  parameter int         WIDTH     = 16,
  parameter int         DELAY_W   = 12,
  parameter logic [6:0] BASE_ADDR = 7'd64
) (
  input  logic                       master_clk,
  input  logic                       reset_n,
  input  logic [6:0]                 serial_addr,
  input  logic [31:0]                serial_data,
  input  logic                       serial_strobe,
  input  logic                       tx_enable,
  input  logic                       rx_enable,
  input  logic                       tx_empty,
  output logic [NUM_BANKS*WIDTH-1:0] io_out,
  output logic [1:0]                 atr_state
);

  logic [7:0]         off;
  logic               wr_hit;
  logic               atr_en_q, fdx_mode_q;
  logic [DELAY_W-1:0] tx_delay_q, rx_delay_q, cnt_q;
  atr_fsm_e           state_q, rest_st;
  logic               go, transmitting;
  logic [1:0]         cls;

  // Offset from the block base; addresses below the base never hit
  assign off    = {1'b0, serial_addr} - {1'b0, BASE_ADDR};
  assign wr_hit = serial_strobe && (serial_addr >= BASE_ADDR);

  assign go           = tx_enable & ~tx_empty;
  assign rest_st      = rx_enable ? ST_RX : ST_IDLE;
  assign transmitting = (state_q == ST_TX) || (state_q == ST_RX_PEND);
  assign cls          = atr_class(transmitting, fdx_mode_q, rx_enable);

  // Global control and delay registers
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      atr_en_q   <= 1'b0;
      fdx_mode_q <= 1'b0;
      tx_delay_q <= '0;
      rx_delay_q <= '0;
    end else if (wr_hit) begin
      case (off)
        OFF_CTRL: begin
          atr_en_q   <= serial_data[0];
          fdx_mode_q <= serial_data[1];
        end
        OFF_TX_DLY: tx_delay_q <= serial_data[DELAY_W-1:0];
        OFF_RX_DLY: rx_delay_q <= serial_data[DELAY_W-1:0];
        default: ;
      endcase
    end
  end

  // TX/RX sequencing FSM with shared delay counter and registered class output
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      atr_state <= CLS_IDLE;
    end else begin
      atr_state <= atr_en_q ? cls : CLS_IDLE;
      if (!atr_en_q) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_RX: begin
            if (go) begin
              if (tx_delay_q == '0) begin
                state_q <= ST_TX;
              end else begin
                state_q <= ST_TX_PEND;
                cnt_q   <= tx_delay_q;
              end
            end else begin
              state_q <= rest_st;
            end
          end
          ST_TX_PEND: begin
            if (!go)                          state_q <= rest_st;
            else if (cnt_q == DELAY_W'(1))    state_q <= ST_TX;
            else                              cnt_q   <= cnt_q - DELAY_W'(1);
          end
          ST_TX: begin
            if (!go) begin
              if (rx_delay_q == '0) begin
                state_q <= rest_st;
              end else begin
                state_q <= ST_RX_PEND;
                cnt_q   <= rx_delay_q;
              end
            end
          end
          ST_RX_PEND: begin
            if (go)                           state_q <= ST_TX;
            else if (cnt_q == DELAY_W'(1))    state_q <= rest_st;
            else                              cnt_q   <= cnt_q - DELAY_W'(1);
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // One register bank per GPIO bank; windows are BANK_STRIDE-aligned above the globals
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [7:0] BANK_OFF = OFF_BANK0 + 8'(b * BANK_STRIDE);
    logic bank_we;
    assign bank_we = wr_hit && (off[7:3] == BANK_OFF[7:3]);

    atr_bank #(
      .WIDTH(WIDTH)
    ) u_bank (
      .clk    (master_clk),
      .rst_n  (reset_n),
      .wr_en  (bank_we),
      .wr_sel (off[2:0]),
      .wr_data(serial_data),
      .atr_en (atr_en_q),
      .cls    (cls),
      .io_out (io_out[b*WIDTH +: WIDTH])
    );
  end

endmodule
